// File: rtl/signmag_decoder_pkg.sv
// -----------------------------------------------------------------------------
// signmag_decoder_pkg
//
// Purpose: shared definitions for the serial two's-complement to
// sign/magnitude decoder. It holds the controller state encoding and the
// default operand width.
//
// Contents:
//   DEFAULT_WIDTH - default operand width in bits
//   state_t       - controller states (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package signmag_decoder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : signmag_decoder_pkg

// File: rtl/serial_neg_cell.sv
// -----------------------------------------------------------------------------
// serial_neg_cell
//
// Purpose: one-bit copy/invert cell for serial two's-complement negation,
// applied LSB first. Bits are copied up to and including the first 1. Every
// bit after that is inverted, but only when the operand is negative.
// Purely combinational.
//
// Ports:
//   data_bit      in  1  current operand bit
//   sign          in  1  operand sign (1 = negative)
//   seen_one      in  1  a 1 has already been consumed from this operand
//   out_bit       out 1  magnitude bit for this position
//   seen_one_next out 1  updated seen_one flag
// -----------------------------------------------------------------------------
module serial_neg_cell (
    input  logic data_bit,
    input  logic sign,
    input  logic seen_one,
    output logic out_bit,
    output logic seen_one_next
);

    assign out_bit       = data_bit ^ (sign & seen_one);
    assign seen_one_next = seen_one | data_bit;

endmodule : serial_neg_cell

// File: rtl/signmag_decoder.sv
// -----------------------------------------------------------------------------
// signmag_decoder
//
// Purpose: converts a two's-complement operand into sign + unsigned magnitude
// with a bit-serial datapath. It takes one operand bit per cycle, LSB first,
// for WIDTH cycles. Valid/ready handshakes are used on both sides.
//
// Timing: the SHIFT phase spans the cycle after the accepting edge and the
// WIDTH-1 cycles after that. out_valid is high after WIDTH+1 rising edges,
// counting the accepting edge as the first. With out_ready tied high, two
// accepts are WIDTH+2 cycles apart.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand available
//   in_ready   out  1      ready to accept (IDLE only)
//   in_data    in   WIDTH  two's-complement operand
//   out_valid  out  1      result available (DONE only)
//   out_ready  in   1      consumer accepts result
//   out_sign   out  1      operand sign, 1 = negative
//   out_mag    out  WIDTH  unsigned magnitude |in_data|
// -----------------------------------------------------------------------------
module signmag_decoder
    import signmag_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag
);

    // Wide enough to hold the value WIDTH.
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] mag_reg;
    logic [CW-1:0]    count_reg;
    logic             sign_reg;
    logic             seen_one_reg;

    logic             accept;
    logic             release_result;
    logic             last_bit;
    logic             cell_out_bit;
    logic             cell_seen_one;

    assign in_ready       = (state_reg == ST_IDLE);
    assign out_valid      = (state_reg == ST_DONE);
    assign accept         = in_valid & in_ready;
    assign release_result = out_valid & out_ready;
    assign last_bit       = (count_reg == CW'(WIDTH - 1));

    // The result is gated so that it reads zero whenever it is not valid.
    // This includes the partial magnitude built up during SHIFT.
    assign out_sign = out_valid & sign_reg;
    assign out_mag  = out_valid ? mag_reg : '0;

    serial_neg_cell u_cell (
        .data_bit      (shift_reg[0]),
        .sign          (sign_reg),
        .seen_one      (seen_one_reg),
        .out_bit       (cell_out_bit),
        .seen_one_next (cell_seen_one)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept)         state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit)       state_next = ST_DONE;
            ST_DONE:  if (release_result) state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // Datapath. Each magnitude bit enters from the MSB side. After WIDTH
    // shifts, the bit taken first from the operand (its LSB) is at mag_reg[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            mag_reg      <= '0;
            count_reg    <= '0;
            sign_reg     <= 1'b0;
            seen_one_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg    <= in_data;
                        sign_reg     <= in_data[WIDTH-1];
                        mag_reg      <= '0;
                        count_reg    <= '0;
                        seen_one_reg <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shift_reg    <= shift_reg >> 1;
                    mag_reg      <= {cell_out_bit, mag_reg[WIDTH-1:1]};
                    seen_one_reg <= cell_seen_one;
                    count_reg    <= count_reg + CW'(1);
                end
                ST_DONE: begin
                    if (release_result) begin
                        mag_reg      <= '0;
                        sign_reg     <= 1'b0;
                        count_reg    <= '0;
                        seen_one_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : signmag_decoder

// File: tb/tb_signmag_decoder.sv
// -----------------------------------------------------------------------------
// tb_signmag_decoder
//
// Purpose: self-checking bench for signmag_decoder with WIDTH = 8. Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_signmag_decoder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_sign;
    logic [W-1:0] out_mag;

    int checks   = 0;
    int failures = 0;

    signmag_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand through the DUT starting from IDLE. It returns the
    // number of edges up to the first one with out_valid high (the accepting
    // edge counts as 1) and the captured result. It then releases the result.
    task automatic run_op(input logic [W-1:0] d, output int edges,
                          output logic s, output logic [W-1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        edges = 1;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
        s = out_sign;
        m = out_mag;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || out_sign !== 1'b0 || out_mag !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b sign=%b mag=%h required 0 0 00",
                     out_valid, out_sign, out_mag);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_vectors();
        logic [W-1:0] vin   [5] = '{8'hFB, 8'h05, 8'h80, 8'hFF, 8'h00};
        logic         vsign [5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
        logic [W-1:0] vmag  [5] = '{8'h05, 8'h05, 8'h80, 8'h01, 8'h00};
        int           edges;
        logic         s;
        logic [W-1:0] m;
        for (int i = 0; i < 5; i++) begin
            run_op(vin[i], edges, s, m);
            checks++;
            if (edges !== 9) begin
                failures++;
                $display("FAIL latency_%h: out_valid after %0d edges required 9", vin[i], edges);
            end
            checks++;
            if (s !== vsign[i] || m !== vmag[i]) begin
                failures++;
                $display("FAIL result_%h: sign=%b mag=%h required sign=%b mag=%h",
                         vin[i], s, m, vsign[i], vmag[i]);
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0 || out_mag !== 8'h00) begin
                failures++;
                $display("FAIL idle_zero_%h: ready=%b valid=%b sign=%b mag=%h required 1 0 0 00",
                         vin[i], in_ready, out_valid, out_sign, out_mag);
            end
            $display("vector in=%h sign=%b mag=%h edges=%0d", vin[i], s, m, edges);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int rises;
        in_valid = 1'b1;
        in_data  = 8'h81;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'h10;
            checks++;
            if (out_valid !== 1'b1 || out_sign !== 1'b1 || out_mag !== 8'h7F || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b sign=%b mag=%h ready=%b required 1 1 7f 0",
                         c, out_valid, out_sign, out_mag, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mag !== 8'h00) begin
            failures++;
            $display("FAIL bp_release: ready=%b valid=%b mag=%h required 1 0 00",
                     in_ready, out_valid, out_mag);
        end
        // The 0x10 offered during DONE must not have been taken.
        rises = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) rises++;
            tick();
        end
        checks++;
        if (rises !== 0) begin
            failures++;
            $display("FAIL bp_ignored_input: out_valid high %0d cycles required 0", rises);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_abort();
        int           rises;
        int           edges;
        logic         s;
        logic [W-1:0] m;
        in_valid = 1'b1;
        in_data  = 8'h9C;
        tick();                 // accepting edge, first SHIFT cycle begins
        in_valid = 1'b0;
        tick();
        tick();                 // now in third SHIFT cycle
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_mag !== 8'h00 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_immediate: ready=%b mag=%h valid=%b required 1 00 0",
                     in_ready, out_mag, out_valid);
        end
        tick();
        tick();
        rst = 1'b0;
        rises = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) rises++;
            tick();
        end
        checks++;
        if (rises !== 0 || in_ready !== 1'b1 || out_mag !== 8'h00) begin
            failures++;
            $display("FAIL abort_no_result: valid_cycles=%0d ready=%b mag=%h required 0 1 00",
                     rises, in_ready, out_mag);
        end
        run_op(8'h9C, edges, s, m);
        checks++;
        if (edges !== 9 || s !== 1'b1 || m !== 8'h64) begin
            failures++;
            $display("FAIL abort_rerun: edges=%0d sign=%b mag=%h required 9 1 64", edges, s, m);
        end
        $display("test_reset_abort rerun sign=%b mag=%h", s, m);
    endtask

    task automatic test_back_to_back();
        int           cyc = 0;
        int           nacc = 0;
        int           nres = 0;
        int           acc_cyc [2] = '{0, 0};
        logic         rs [2] = '{1'b0, 1'b0};
        logic [W-1:0] rm [2] = '{8'h00, 8'h00};
        logic         acc_now;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hF0;
        for (int c = 0; c < 60 && nres < 2; c++) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                rs[nres] = out_sign;
                rm[nres] = out_mag;
                nres++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc == 1) in_data = 8'h7F;
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (nres !== 2 || nacc !== 2) begin
            failures++;
            $display("FAIL b2b_count: results=%0d accepts=%0d required 2 2", nres, nacc);
        end
        checks++;
        if (rs[0] !== 1'b1 || rm[0] !== 8'h10 || rs[1] !== 1'b0 || rm[1] !== 8'h7F) begin
            failures++;
            $display("FAIL b2b_results: (%b,%h) (%b,%h) required (1,10) (0,7f)",
                     rs[0], rm[0], rs[1], rm[1]);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 10) begin
            failures++;
            $display("FAIL b2b_spacing: %0d cycles required 10", acc_cyc[1] - acc_cyc[0]);
        end
        $display("test_back_to_back spacing=%0d", acc_cyc[1] - acc_cyc[0]);
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] d;
        logic [W-1:0] exp_mag;
        logic         exp_sign;
        logic         prev_valid = 1'b0;
        logic         prev_rel   = 1'b0;
        logic [W-1:0] prev_mag   = '0;
        int           nres = 0;
        int           nacc = 0;
        int           errs_before = failures;
        for (int c = 0; c < 40000 && nres < 1000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1) && (nacc < 1000);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #0;
            if (out_valid && prev_valid && !prev_rel) begin
                checks++;
                if (out_mag !== prev_mag) begin
                    failures++;
                    $display("FAIL rand_stable: mag=%h required %h", out_mag, prev_mag);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                nacc++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra_result: sign=%b mag=%h with nothing pending",
                             out_sign, out_mag);
                end else begin
                    d        = q.pop_front();
                    exp_sign = d[W-1];
                    exp_mag  = d[W-1] ? (~d + 8'h01) : d;
                    if (out_sign !== exp_sign || out_mag !== exp_mag) begin
                        failures++;
                        $display("FAIL rand_result_%0d: in=%h sign=%b mag=%h required sign=%b mag=%h",
                                 nres, d, out_sign, out_mag, exp_sign, exp_mag);
                    end
                end
                nres++;
            end
            prev_valid = out_valid;
            prev_rel   = out_valid && out_ready;
            prev_mag   = out_mag;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nres !== 1000 || q.size() !== 0) begin
            failures++;
            $display("FAIL rand_totals: results=%0d pending=%0d required 1000 0", nres, q.size());
        end
        $display("test_random results=%0d accepts=%0d new_failures=%0d",
                 nres, nacc, failures - errs_before);
    endtask

    initial begin
        #1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_signmag_decoder

// File: doc/signmag_decoder.md
SIGNMAG_DECODER -- requirements
Module: signmag_decoder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  two's-complement operand available.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand.
REQ-006 SHALL have port: in_data  input  WIDTH  two's-complement operand.
REQ-007 SHALL have port: out_valid  output  1  result available.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port: out_sign  output  1  sign of the operand (1 = negative).
REQ-010 SHALL have port: out_mag  output  WIDTH  unsigned magnitude |in_data|.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-013 IDLE: on in_valid & in_ready, SHALL capture in_data into a shift register, latch sign = in_data[WIDTH-1], clear bit counter and seen_one flag, and go to SHIFT.
REQ-014 SHIFT: each cycle SHALL consume one operand bit, LSB first; output bit = b XOR (sign & seen_one); then seen_one |= b; output bit is shifted into out_mag from the MSB side.
REQ-015 SHIFT SHALL last exactly WIDTH cycles regardless of sign. Positive operands pass through unchanged; negative operands use the serial copy-to-first-one-then-invert rule.
REQ-016 After the WIDTH-th SHIFT cycle, the FSM SHALL go to DONE. out_valid SHALL rise exactly WIDTH+1 rising edges after the accepting edge.
REQ-017 DONE: out_sign and out_mag SHALL hold stable until out_valid & out_ready, then go to IDLE. No operand is accepted in that same cycle, so the minimum spacing between accepts is WIDTH+2 cycles.
REQ-018 SHALL ignore in_valid and in_data outside IDLE. SHALL ignore out_ready outside DONE.
REQ-019 Most-negative input (1 followed by zeros) SHALL yield out_sign = 1 and out_mag = 2^(WIDTH-1), which is representable unsigned. No overflow flag.
REQ-020 Zero input SHALL yield out_sign = 0 and out_mag = 0.
REQ-021 out_mag and out_sign SHALL be valid only while out_valid = 1. They SHALL be zero in IDLE.

Reset
REQ-022 While rst = 1, SHALL be in IDLE with out_valid = 0, out_sign = 0, out_mag = 0, counter = 0, seen_one = 0. in_ready SHALL read 1 once rst deasserts.
REQ-023 Reset asserted in SHIFT or DONE SHALL abort the operation immediately (asynchronous). The partial result SHALL be discarded, with no out_valid pulse.

Structure
REQ-024 A shared package SHALL hold the FSM state enum (IDLE/SHIFT/DONE) and the default WIDTH constant.
REQ-025 One sub-module SHALL be instantiated: serial_neg_cell. It is the one-bit copy/invert cell: inputs bit, sign, seen_one; outputs out_bit and next seen_one. It is purely combinational.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide.

Verification
REQ-027 Accept 0xFB (-5) -> after 9 edges: out_valid = 1, out_sign = 1, out_mag = 0x05.
REQ-028 Accept 0x05 -> out_sign = 0, out_mag = 0x05. Accept 0x80 -> out_sign = 1, out_mag = 0x80. Accept 0xFF -> out_sign = 1, out_mag = 0x01. Accept 0x00 -> out_sign = 0, out_mag = 0x00.
REQ-029 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable and in_ready = 0; a new in_valid pulse with 0x10 is ignored. Then raise out_ready -> IDLE the next cycle, in_ready = 1.
REQ-030 Assert rst during the 3rd SHIFT cycle of 0x9C -> out_valid never rises, out_mag = 0, in_ready = 1 after release. A following accept of 0x9C gives out_sign = 1, out_mag = 0x64.
REQ-031 Back-to-back: in_valid held high with 0xF0 then 0x7F, out_ready tied 1 -> results (1, 0x10) then (0, 0x7F), accepts spaced exactly 10 cycles.
REQ-032 Random: 1000 operands with random in_valid/out_ready -> every result matches the reference sign/abs model, and no result is lost or duplicated.
